// File: rtl/mult_div.sv
// mult_div: multi-cycle multiply/divide unit that owns the HI/LO register pair.
// Results are computed when an operation is accepted and held in a pending
// register. They are committed to HI/LO only when the latency counter expires,
// so the pipeline observes the fixed MUL_CYCLES / DIV_CYCLES latency.
module mult_div #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_BITS = $clog2(MAX_CYC + 1);
  localparam int CNT_W    = (CNT_BITS > 4) ? CNT_BITS : 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [63:0]        r_pend;     // {HI, LO} to commit at completion
  logic               r_pend_wr;  // cleared for divide-by-zero: HI/LO keep their value

  logic [63:0]        w_result;
  logic               w_wr;
  logic [CNT_W-1:0]   w_cnt_load;

  // Unsigned 32x32 -> 64 product.
  function automatic logic [63:0] f_mul_u(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    a_ext = {32'd0, a};
    b_ext = {32'd0, b};
    return a_ext * b_ext;
  endfunction

  // Signed 32x32 -> 64 product: sign-extend both operands, then keep the low 64 bits.
  function automatic logic [63:0] f_mul_s(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    a_ext = {{32{a[31]}}, a};
    b_ext = {{32{b[31]}}, b};
    return a_ext * b_ext;
  endfunction

  // Unsigned divide, returns {remainder, quotient}. A zero divisor yields zero.
  // The caller suppresses the write in that case.
  function automatic logic [63:0] f_div_u(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Signed divide on magnitudes. The quotient truncates toward zero, and the
  // remainder takes the dividend's sign. 0x80000000 / -1 naturally gives
  // quotient 0x80000000 and remainder 0, because the magnitude wraps back onto itself.
  function automatic logic [63:0] f_div_s(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q;
    logic [31:0] r;
    mag_a = a[31] ? (32'd0 - a) : a;
    mag_b = b[31] ? (32'd0 - b) : b;
    if (mag_b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = mag_a / mag_b;
      r = mag_a % mag_b;
    end
    if (a[31] ^ b[31]) begin
      q = 32'd0 - q;
    end else begin
      q = q;
    end
    if (a[31]) begin
      r = 32'd0 - r;
    end else begin
      r = r;
    end
    return {r, q};
  endfunction

  // Select the result, write qualifier and latency for the requested arithmetic op.
  always_comb begin
    w_result   = 64'd0;
    w_wr       = 1'b1;
    w_cnt_load = CNT_W'(MUL_CYCLES);
    case (MDOp)
      3'b000: begin
        w_result   = f_mul_s(A, B);
        w_cnt_load = CNT_W'(MUL_CYCLES);
      end
      3'b001: begin
        w_result   = f_mul_u(A, B);
        w_cnt_load = CNT_W'(MUL_CYCLES);
      end
      3'b010: begin
        w_result   = f_div_s(A, B);
        w_wr       = (B != 32'd0);
        w_cnt_load = CNT_W'(DIV_CYCLES);
      end
      3'b011: begin
        w_result   = f_div_u(A, B);
        w_wr       = (B != 32'd0);
        w_cnt_load = CNT_W'(DIV_CYCLES);
      end
      default: begin
        w_result   = 64'd0;
        w_wr       = 1'b0;
        w_cnt_load = CNT_W'(MUL_CYCLES);
      end
    endcase
  end

  // Control FSM: accept ops in IDLE, count down in RUN, commit HI/LO on expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend    <= 64'd0;
      r_pend_wr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            case (MDOp)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                r_pend    <= w_result;
                r_pend_wr <= w_wr;
                r_cnt     <= w_cnt_load;
                r_busy    <= 1'b1;
                r_state   <= S_RUN;
              end
              3'b100:  r_hi <= A;
              3'b101:  r_lo <= A;
              default: r_hi <= r_hi;
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          // Start is deliberately ignored here; the operands are already captured.
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt <= CNT_W'(1)) begin
            if (r_pend_wr) begin
              r_hi <= r_pend[63:32];
              r_lo <= r_pend[31:0];
            end else begin
              r_hi <= r_hi;
            end
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div.sv
// Directed testbench for mult_div with hand-computed expected HI/LO values.
module tb_mult_div;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic [2:0]  MDOp;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks;
  int n_fail;

  mult_div #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .Start (Start),
    .MDOp  (MDOp),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue an arithmetic op at the current negedge and track it to completion.
  // With disturb set, A/B are scrambled and Start is pulsed with mult/mtlo
  // during the run, including on the completion edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit disturb);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {63'd0, Busy}, 64'd1);
      chk({tag, "_hold"}, {HI, LO}, {prev_hi, prev_lo});
      if (disturb) begin
        A     = $urandom;
        B     = $urandom;
        Start = 1'b1;
        MDOp  = (i % 2 == 0) ? 3'b000 : 3'b101;
      end
      @(negedge clk);
    end
    Start = 1'b0;
    MDOp  = 3'b110;
    chk({tag, "_done"}, {63'd0, Busy}, 64'd0);
    chk({tag, "_res"}, {HI, LO}, {exp_hi, exp_lo});
  endtask

  // Single-cycle mthi/mtlo/no-op issued at the current negedge.
  task automatic mt_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    Start = 1'b1; MDOp = op; A = a;
    @(negedge clk);
    Start = 1'b0;
    chk({tag, "_busy"}, {63'd0, Busy}, 64'd0);
    chk({tag, "_res"}, {HI, LO}, {exp_hi, exp_lo});
  endtask

  // Directed sequence.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; A = 32'd0; B = 32'd0; Start = 1'b0; MDOp = 3'b110;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_hilo", {HI, LO}, 64'd0);

    run_op("mult", 3'b000, 32'hFFFFFFFF, 32'h00000002, 5,
           32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("multu", 3'b001, 32'hFFFFFFFF, 32'h00000002, 5,
           32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_op("mult_mix", 3'b000, 32'h00000007, 32'hFFFFFFFD, 5,
           32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("div", 3'b010, 32'hFFFFFFF9, 32'h00000002, 10,
           32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu", 3'b011, 32'h00000007, 32'h00000002, 10,
           32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001, 32'h00000003, 1'b0);
    run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 10,
           32'h00000001, 32'h00000003, 32'h00000000, 32'h80000000, 1'b0);

    mt_op("mthi", 3'b100, 32'h12345678, 32'h12345678, 32'h80000000);
    mt_op("mtlo", 3'b101, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0);
    mt_op("noop", 3'b111, 32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0);

    run_op("divu0", 3'b011, 32'h00000055, 32'h00000000, 10,
           32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    run_op("div0", 3'b010, 32'hFFFFFF00, 32'h00000000, 10,
           32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1'b0);

    // Disturbed run: the completion-edge Start is ignored, and the next op is
    // accepted on the following edge (it starts straight away below).
    run_op("mult_dist", 3'b000, 32'h00000003, 32'h00000005, 5,
           32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0000000F, 1'b1);
    run_op("b2b_divu", 3'b011, 32'h00000064, 32'h00000007, 10,
           32'h00000000, 32'h0000000F, 32'h00000002, 32'h0000000E, 1'b0);

    // Reset during the third cycle of a divide aborts it.
    Start = 1'b1; MDOp = 3'b010; A = 32'h00000064; B = 32'h00000007;
    @(negedge clk);
    Start = 1'b0;
    chk("abort_busy_run", {63'd0, Busy}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    chk("abort_hilo", {HI, LO}, 64'd0);
    for (int i = 0; i < 12; i++) @(negedge clk);
    chk("abort_nolate_busy", {63'd0, Busy}, 64'd0);
    chk("abort_nolate_hilo", {HI, LO}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div.md
# mult_div

Multi-cycle multiply/divide unit in the execute stage, alongside the ALU. Receives the same two 32-bit operands the ALU sees; the B operand may come from the immediate extender through the operand mux. Performs signed/unsigned multiply and divide into the HI/LO register pair, serves mthi/mtlo writes, and raises Busy so the hazard unit stalls dependent HI/LO instructions.

## Interface
- MUL_CYCLES, default 5: cycles from accepted start to HI/LO update for mult/multu.
- DIV_CYCLES, default 10: cycles from accepted start to HI/LO update for div/divu.

- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  32  operand rs (dividend / multiplicand / mthi/mtlo data).
- B  input  32  operand rt or extended immediate (divisor / multiplier).
- Start  input  1  one-cycle request strobe, qualified by MDOp.
- MDOp  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 no-op.
- Busy  output  1  registered; high while an operation is in flight.
- HI  output  32  registered HI (product high word / remainder).
- LO  output  32  registered LO (product low word / quotient).

## Operation
- States: IDLE, RUN. Down-counter cnt, 4 bits minimum (must hold max(MUL_CYCLES, DIV_CYCLES)).
- IDLE, Start=1, MDOp in {000..011}: latch A, B, MDOp; compute result into internal pending registers (behavioural * and / allowed); cnt <= MUL_CYCLES or DIV_CYCLES; go RUN; Busy <= 1.
- IDLE, Start=1, MDOp=100: HI <= A next edge; MDOp=101: LO <= A. Busy stays 0.
- IDLE, Start=1, MDOp 110/111: no effect.
- RUN: cnt decrements each edge; on the edge where cnt reaches 1, HI/LO <= pending result, Busy <= 0, go IDLE.
- Start during RUN (any MDOp): ignored; no operand latch, no mthi/mtlo write. The hazard unit guarantees this does not occur; the unit must still be robust to it.
- mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0]. multu: unsigned.
- div: signed; quotient truncated toward zero -> LO; remainder takes the sign of the dividend -> HI.
- divu: unsigned quotient -> LO, remainder -> HI.
- Divide by zero (B=0, div or divu): full DIV_CYCLES latency and Busy behaviour; HI and LO unchanged at completion.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000.
- Operands latched at start; changes to A/B during RUN do not affect the result.

## Timing
- Reset: Busy=0, HI=0x00000000, LO=0x00000000, state IDLE, cnt=0. Reset during RUN aborts; pending result discarded.
- Start sampled at edge k: Busy high after edge k, low after edge k+N (N = MUL_CYCLES or DIV_CYCLES); HI/LO show the new value after edge k+N. Busy is high for exactly N cycles.
- Back-to-back: Start may be accepted on edge k+N+1, the first edge with Busy=0 sampled. A Start coinciding with the completion edge k+N is ignored, because Busy=1 is sampled.
- mthi/mtlo: single-cycle; value visible after the sampling edge; Busy never asserts.
- HI/LO hold their value in all cycles other than reset, completion, and mthi/mtlo.
- The hazard unit stalls mfhi/mflo and md instructions on (Busy | Start); Start is not folded into Busy here.

## Test plan
- Reset, then mult A=0xFFFFFFFF B=0x00000002 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; HI/LO stay 0 until the completion edge.
- multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div A=0xFFFFFFF9 (-7) B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7 B=2 -> LO=3, HI=1. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload mthi 0x12345678 and mtlo 0x9ABCDEF0, then divu by 0 -> Busy 10 cycles; HI/LO unchanged.
- During RUN: toggle A/B, issue Start with mult and mtlo -> result matches the latched operands; LO is not overwritten by mtlo. Start on the completion edge is ignored; Start on the next edge is accepted.
- Assert reset on cycle 3 of a div -> next cycle Busy=0, HI=LO=0; no late write occurs.
